// File: rtl/mem_access_stage.sv
// MEM pipeline stage: decodes the EX/MEM instruction and runs loads/stores on a req/ack data memory.
// Latency: 1 cycle for non-memory/misaligned ops; memory ops retire on the edge after dm_ack or timeout.
// Backpressure: stall holds upstream from decode of an aligned memory op until the dm_ack cycle.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_instr,
    input  logic [31:0] mem_alu,
    input  logic [31:0] mem_sdata,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        mw_valid,
    output logic [31:0] mw_instr,
    output logic [31:0] mw_result,
    output logic [1:0]  mw_excp
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_nxt;

    logic        is_mem, is_store, sext_c, aligned, start, timed_out;
    logic [1:0]  size_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    logic [31:0] acc_instr, acc_alu;
    logic [1:0]  acc_size;
    logic        acc_sext;
    logic [CW-1:0] cnt;
    logic [31:0] lane_data, load_data;

    // size_c doubles as the alignment mask: 00 byte, 01 halfword, 11 word
    always_comb begin
        is_mem   = 1'b1;
        is_store = 1'b0;
        sext_c   = 1'b0;
        size_c   = 2'd0;
        case (mem_instr[31:26])
            6'h20: sext_c = 1'b1;
            6'h21: begin size_c = 2'd1; sext_c = 1'b1; end
            6'h23: size_c = 2'd3;
            6'h24: size_c = 2'd0;
            6'h25: size_c = 2'd1;
            6'h28: is_store = 1'b1;
            6'h29: begin size_c = 2'd1; is_store = 1'b1; end
            6'h2b: begin size_c = 2'd3; is_store = 1'b1; end
            default: is_mem = 1'b0;
        endcase
        aligned = (mem_alu[1:0] & size_c) == 2'b00;
        start   = mem_valid && is_mem && aligned;

        be_c    = 4'b1111;
        wdata_c = mem_sdata;
        case (size_c)
            2'd0: begin
                be_c    = 4'b0001 << mem_alu[1:0];
                wdata_c = {4{mem_sdata[7:0]}};
            end
            2'd1: begin
                be_c    = mem_alu[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{mem_sdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Loads pick their lane from the registered address; an aligned word shifts by zero
    assign lane_data = dm_rdata >> {acc_alu[1:0], 3'b000};

    always_comb begin
        case (acc_size)
            2'd0:    load_data = {{24{acc_sext & lane_data[7]}}, lane_data[7:0]};
            2'd1:    load_data = {{16{acc_sext & lane_data[15]}}, lane_data[15:0]};
            default: load_data = lane_data;
        endcase
    end

    assign timed_out = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCESS;
            ACCESS:  if (dm_ack || timed_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        if (!Reset) begin
            case (state)
                IDLE:    stall = start;
                ACCESS:  stall = !dm_ack;
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_be     <= 4'b0;
            dm_addr   <= 32'b0;
            dm_wdata  <= 32'b0;
            mw_valid  <= 1'b0;
            mw_instr  <= 32'b0;
            mw_result <= 32'b0;
            mw_excp   <= 2'b00;
            acc_instr <= 32'b0;
            acc_alu   <= 32'b0;
            acc_size  <= 2'd0;
            acc_sext  <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!mem_valid) begin
                        mw_valid <= 1'b0;
                    end else if (!is_mem || !aligned) begin
                        mw_valid  <= 1'b1;
                        mw_instr  <= mem_instr;
                        mw_result <= mem_alu;
                        mw_excp   <= is_mem ? 2'b01 : 2'b00;
                    end else begin
                        mw_valid  <= 1'b0;
                        dm_req    <= 1'b1;
                        dm_we     <= is_store;
                        dm_be     <= be_c;
                        dm_addr   <= {mem_alu[31:2], 2'b00};
                        dm_wdata  <= wdata_c;
                        acc_instr <= mem_instr;
                        acc_alu   <= mem_alu;
                        acc_size  <= size_c;
                        acc_sext  <= sext_c;
                        cnt       <= '0;
                    end
                end
                ACCESS: begin
                    if (dm_ack || timed_out) begin
                        dm_req    <= 1'b0;
                        mw_valid  <= 1'b1;
                        mw_instr  <= acc_instr;
                        mw_result <= (dm_ack && !dm_we) ? load_data : acc_alu;
                        mw_excp   <= dm_ack ? 2'b00 : 2'b10;
                    end else begin
                        mw_valid <= 1'b0;
                        cnt      <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus randomized ops checked against a byte-level model.
module tb_mem_access_stage;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_instr = '0, mem_alu = '0, mem_sdata = '0;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        stall, dm_req, dm_we, mw_valid;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, mw_instr, mw_result;
    logic [1:0]  mw_excp;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    typedef struct {
        bit          done;
        logic [31:0] instr, result;
        logic [1:0]  excp;
        int          stall_n, req_n;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr, wdata;
        bit          unstable;
    } obs_t;

    typedef struct {
        logic [31:0] result;
        logic [1:0]  excp;
        int          stall_n, req_n;
        bit          access;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr, wdata;
    } exp_t;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .Reset(Reset),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_alu(mem_alu), .mem_sdata(mem_sdata),
        .stall(stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mw_valid(mw_valid), .mw_instr(mw_instr), .mw_result(mw_result), .mw_excp(mw_excp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    // Reference: access width in bytes, lanes and extension computed arithmetically
    function automatic exp_t model(input logic [31:0] instr, alu, sd, rd, input int dly);
        exp_t e;
        int size, off;
        bit sgn, st;
        logic [63:0] v, full;
        size = 0; sgn = 0; st = 0;
        case (instr[31:26])
            6'h20: begin size = 1; sgn = 1; end
            6'h21: begin size = 2; sgn = 1; end
            6'h23: size = 4;
            6'h24: size = 1;
            6'h25: size = 2;
            6'h28: begin size = 1; st = 1; end
            6'h29: begin size = 2; st = 1; end
            6'h2B: begin size = 4; st = 1; end
            default: size = 0;
        endcase
        off = int'(alu % 4);
        e.result = alu; e.excp = 2'b00; e.stall_n = 0; e.req_n = 0; e.access = 0;
        e.we = st; e.be = 4'b0; e.addr = 32'b0; e.wdata = 32'b0;
        if (size != 0 && off % size != 0) begin
            e.excp = 2'b01;
        end else if (size != 0) begin
            e.access = 1;
            e.addr = alu - 32'(off);
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + size) e.be[i] = 1'b1;
                e.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
            end
            if (dly < TO) begin
                e.req_n = dly + 1;
                e.stall_n = dly + 1;
                if (!st) begin
                    v = {32'd0, rd} >> (8 * off);
                    full = 64'd1 << (8 * size);
                    v = v & (full - 64'd1);
                    if (sgn && v >= full / 2) v = v - full;
                    e.result = v[31:0];
                end
            end else begin
                e.req_n = TO;
                e.stall_n = TO + 1;
                e.excp = 2'b10;
            end
        end
        return e;
    endfunction

    // Presents one op as the upstream stage and plays memory; ack comes dly cycles after req rises
    task automatic do_op(input logic [31:0] instr, alu, sd, rd, input int dly, output obs_t o);
        int reqn;
        reqn = 0;
        o.done = 0; o.instr = '0; o.result = '0; o.excp = '0; o.stall_n = 0; o.req_n = 0;
        o.we = 0; o.be = '0; o.addr = '0; o.wdata = '0; o.unstable = 0;
        mem_valid = 1'b1; mem_instr = instr; mem_alu = alu; mem_sdata = sd;
        for (int c = 0; c < TO + 8 && !o.done; c++) begin
            dm_ack = dm_req && (reqn == dly);
            dm_rdata = dm_ack ? rd : $urandom;
            if (dm_req === 1'b1) begin
                if (reqn == 0) begin
                    o.we = dm_we; o.be = dm_be; o.addr = dm_addr; o.wdata = dm_wdata;
                end else if (dm_we !== o.we || dm_be !== o.be || dm_addr !== o.addr || dm_wdata !== o.wdata) begin
                    o.unstable = 1;
                end
                reqn++;
            end
            @(negedge clk);
            if (stall === 1'b1) o.stall_n++;
            @(posedge clk); #1;
            if (mw_valid === 1'b1) begin
                o.done = 1; o.instr = mw_instr; o.result = mw_result; o.excp = mw_excp;
            end
        end
        o.req_n = reqn;
        dm_ack = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({stall, dm_req, dm_we, mw_valid} !== 4'b0000)
            $display("FAIL reset_ctrl: stall/req/we/valid=%b required 0000", {stall, dm_req, dm_we, mw_valid});
        else n_pass++;
        n_checks++;
        if (dm_be !== 4'b0 || dm_addr !== 32'b0 || dm_wdata !== 32'b0)
            $display("FAIL reset_bus: be=%b addr=%h wdata=%h required zeros", dm_be, dm_addr, dm_wdata);
        else n_pass++;
        n_checks++;
        if (mw_instr !== 32'b0 || mw_result !== 32'b0 || mw_excp !== 2'b00)
            $display("FAIL reset_mw: instr=%h result=%h excp=%b required zeros", mw_instr, mw_result, mw_excp);
        else n_pass++;
        @(posedge clk); #1;
        Reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (mw_valid !== 1'b0 || dm_req !== 1'b0 || stall !== 1'b0)
            $display("FAIL reset_release: valid=%b req=%b stall=%b required 000", mw_valid, dm_req, stall);
        else n_pass++;
    endtask

    task automatic test_alu;
        obs_t o;
        do_op({6'h00, 26'h0000_123}, 32'h1234, 32'h5555_5555, 32'h0, 0, o);
        n_checks++;
        if (o.stall_n != 0 || o.req_n != 0)
            $display("FAIL alu_nostall: stall_cycles=%0d req_cycles=%0d required 0 0", o.stall_n, o.req_n);
        else n_pass++;
        n_checks++;
        if (o.done !== 1'b1 || o.result !== 32'h1234 || o.excp !== 2'b00 || o.instr !== {6'h00, 26'h0000_123})
            $display("FAIL alu_result: done=%0b result=%h excp=%b instr=%h required 1 00001234 00", o.done, o.result, o.excp, o.instr);
        else n_pass++;
        // stray acks while idle must not start anything
        dm_ack = 1'b1;
        repeat (2) begin
            dm_rdata = $urandom;
            @(posedge clk); #1;
            n_checks++;
            if (dm_req !== 1'b0 || mw_valid !== 1'b0 || stall !== 1'b0)
                $display("FAIL idle_ack: req=%b valid=%b stall=%b required 000", dm_req, mw_valid, stall);
            else n_pass++;
        end
        dm_ack = 1'b0;
    endtask

    task automatic test_directed;
        obs_t o;
        do_op({6'h20, 26'h0}, 32'h1003, 32'h0, 32'h80FF_0000, 3, o);
        n_checks++;
        if (o.be !== 4'b1000 || o.we !== 1'b0 || o.addr !== 32'h1000)
            $display("FAIL lb_bus: be=%b we=%b addr=%h required 1000 0 00001000", o.be, o.we, o.addr);
        else n_pass++;
        n_checks++;
        if (o.stall_n != 4 || o.req_n != 4)
            $display("FAIL lb_timing: stall_cycles=%0d req_cycles=%0d required 4 4", o.stall_n, o.req_n);
        else n_pass++;
        n_checks++;
        if (o.done !== 1'b1 || o.result !== 32'hFFFF_FF80 || o.excp !== 2'b00)
            $display("FAIL lb_result: result=%h excp=%b required ffffff80 00", o.result, o.excp);
        else n_pass++;

        do_op({6'h25, 26'h0}, 32'h1002, 32'h0, 32'hABCD_0000, 1, o);
        n_checks++;
        if (o.be !== 4'b1100 || o.result !== 32'h0000_ABCD || o.excp !== 2'b00)
            $display("FAIL lhu: be=%b result=%h excp=%b required 1100 0000abcd 00", o.be, o.result, o.excp);
        else n_pass++;

        do_op({6'h21, 26'h0}, 32'h1002, 32'h0, 32'hABCD_0000, 0, o);
        n_checks++;
        if (o.be !== 4'b1100 || o.result !== 32'hFFFF_ABCD)
            $display("FAIL lh: be=%b result=%h required 1100 ffffabcd", o.be, o.result);
        else n_pass++;

        do_op({6'h29, 26'h0}, 32'h2002, 32'h0000_BEEF, 32'h0, 2, o);
        n_checks++;
        if (o.we !== 1'b1 || o.be !== 4'b1100 || o.wdata !== 32'hBEEF_BEEF || o.addr !== 32'h2000 || o.unstable)
            $display("FAIL sh_bus: we=%b be=%b wdata=%h addr=%h unstable=%0b required 1 1100 beefbeef 00002000 0",
                     o.we, o.be, o.wdata, o.addr, o.unstable);
        else n_pass++;
        n_checks++;
        if (o.result !== 32'h2002 || o.excp !== 2'b00)
            $display("FAIL sh_result: result=%h excp=%b required 00002002 00", o.result, o.excp);
        else n_pass++;

        do_op({6'h23, 26'h0}, 32'h1001, 32'h0, 32'h0, 0, o);
        n_checks++;
        if (o.req_n != 0 || o.stall_n != 0 || o.excp !== 2'b01 || o.result !== 32'h1001)
            $display("FAIL lw_misaligned: req_cycles=%0d stall_cycles=%0d excp=%b result=%h required 0 0 01 00001001",
                     o.req_n, o.stall_n, o.excp, o.result);
        else n_pass++;
    endtask

    task automatic test_timeout;
        obs_t o;
        do_op({6'h2B, 26'h0}, 32'h4000, 32'hCAFE_F00D, 32'h0, 1000, o);
        n_checks++;
        if (o.req_n != TO || o.stall_n != TO + 1)
            $display("FAIL timeout_len: req_cycles=%0d stall_cycles=%0d required %0d %0d", o.req_n, o.stall_n, TO, TO + 1);
        else n_pass++;
        n_checks++;
        if (o.done !== 1'b1 || o.excp !== 2'b10 || o.result !== 32'h4000)
            $display("FAIL timeout_excp: done=%0b excp=%b result=%h required 1 10 00004000", o.done, o.excp, o.result);
        else n_pass++;
        #1;
        n_checks++;
        if (stall !== 1'b0 || dm_req !== 1'b0)
            $display("FAIL timeout_release: stall=%b req=%b required 0 0", stall, dm_req);
        else n_pass++;

        do_op({6'h2B, 26'h0}, 32'h4004, 32'h1234_5678, 32'h0, TO - 1, o);
        n_checks++;
        if (o.req_n != TO || o.excp !== 2'b00 || o.result !== 32'h4004)
            $display("FAIL ack_wins: req_cycles=%0d excp=%b result=%h required %0d 00 00004004", o.req_n, o.excp, o.result, TO);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        obs_t o1, o2, o3;
        exp_t e1, e2;
        int t0, d1, d2;
        logic [31:0] a1, a2, r1, r2;
        d1 = int'($urandom_range(0, 4));
        d2 = int'($urandom_range(0, 4));
        a1 = {$urandom} & 32'hFFFF_FFFC;
        a2 = $urandom;
        r1 = $urandom;
        r2 = $urandom;
        e1 = model({6'h23, 26'h0}, a1, 32'h0, r1, d1);
        e2 = model({6'h24, 26'h0}, a2, 32'h0, r2, d2);
        t0 = cyc;
        do_op({6'h23, 26'h0}, a1, 32'h0, r1, d1, o1);
        do_op({6'h24, 26'h0}, a2, 32'h0, r2, d2, o2);
        do_op({6'h00, 26'h7}, 32'h9999, 32'h0, 32'h0, 0, o3);
        n_checks++;
        if (cyc - t0 != (d1 + 2) + (d2 + 2) + 1)
            $display("FAIL b2b_cycles: took %0d cycles required %0d", cyc - t0, (d1 + 2) + (d2 + 2) + 1);
        else n_pass++;
        n_checks++;
        if (o1.result !== e1.result || o2.result !== e2.result || o3.result !== 32'h9999)
            $display("FAIL b2b_results: got %h %h %h required %h %h 00009999", o1.result, o2.result, o3.result, e1.result, e2.result);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        obs_t o;
        mem_valid = 1'b1; mem_instr = {6'h2B, 26'h0}; mem_alu = 32'h3000; mem_sdata = 32'hA5A5_A5A5; dm_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dm_req !== 1'b1 || stall !== 1'b1)
            $display("FAIL midreset_pre: req=%b stall=%b required 1 1", dm_req, stall);
        else n_pass++;
        Reset = 1'b1;
        #1;
        n_checks++;
        if (dm_req !== 1'b0 || stall !== 1'b0 || mw_valid !== 1'b0)
            $display("FAIL midreset_drop: req=%b stall=%b valid=%b required 0 0 0", dm_req, stall, mw_valid);
        else n_pass++;
        mem_valid = 1'b0;
        @(posedge clk); #1;
        Reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (dm_req !== 1'b0 || stall !== 1'b0 || mw_valid !== 1'b0)
            $display("FAIL midreset_idle: req=%b stall=%b valid=%b required 0 0 0", dm_req, stall, mw_valid);
        else n_pass++;
        do_op({6'h00, 26'h1}, 32'h0BAD_CAFE, 32'h0, 32'h0, 0, o);
        n_checks++;
        if (o.done !== 1'b1 || o.result !== 32'h0BAD_CAFE || o.stall_n != 0)
            $display("FAIL midreset_after: done=%0b result=%h stall_cycles=%0d required 1 0badcafe 0", o.done, o.result, o.stall_n);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [5:0] ops [12] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                                 6'h00, 6'h0F, 6'h22, 6'h2A};
        obs_t o;
        exp_t e;
        logic [31:0] instr, alu, sd, rd;
        int r, dly;
        for (int n = 0; n < 120; n++) begin
            instr = {ops[$urandom_range(0, 11)], 26'($urandom)};
            alu = $urandom;
            sd = $urandom;
            rd = $urandom;
            r = int'($urandom_range(0, 9));
            dly = (r < 6) ? r : (r == 6) ? TO - 1 : (r == 7) ? 1000 : int'($urandom_range(0, TO - 1));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                n_checks++;
                if (mw_valid !== 1'b0)
                    $display("FAIL rand_bubble: mw_valid=%b required 0", mw_valid);
                else n_pass++;
            end
            e = model(instr, alu, sd, rd, dly);
            do_op(instr, alu, sd, rd, dly, o);
            n_checks++;
            if (o.done !== 1'b1 || o.instr !== instr || o.result !== e.result || o.excp !== e.excp)
                $display("FAIL rand_result[%0d]: done=%0b instr=%h result=%h excp=%b required instr=%h result=%h excp=%b",
                         n, o.done, o.instr, o.result, o.excp, instr, e.result, e.excp);
            else n_pass++;
            n_checks++;
            if (o.stall_n != e.stall_n || o.req_n != e.req_n)
                $display("FAIL rand_timing[%0d]: stall_cycles=%0d req_cycles=%0d required %0d %0d",
                         n, o.stall_n, o.req_n, e.stall_n, e.req_n);
            else n_pass++;
            if (e.access) begin
                n_checks++;
                if (o.we !== e.we || o.be !== e.be || o.addr !== e.addr || (e.we && o.wdata !== e.wdata) || o.unstable)
                    $display("FAIL rand_bus[%0d]: we=%b be=%b addr=%h wdata=%h unstable=%0b required we=%b be=%b addr=%h wdata=%h",
                             n, o.we, o.be, o.addr, o.wdata, o.unstable, e.we, e.be, e.addr, e.wdata);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_directed();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
